// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the sliced wide adder.
// Slice geometry and FSM encoding live here.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int CLA_BASE_WIDTH = 4;

  function automatic int unsigned slice_lsb(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/nBitCarryLookAheadAdder.sv
// NUMBITS-wide adder built from 4-bit lookahead groups.
// Group carries chain from one group to the next.
module nBitCarryLookAheadAdder
  import add_seq_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a_i,
  input  logic [NUMBITS-1:0] b_i,
  input  logic               c_i,
  output logic [NUMBITS-1:0] s_o,
  output logic               c_o
);

  localparam int W  = CLA_BASE_WIDTH;
  localparam int NG = NUMBITS / W;

  if (NUMBITS % W != 0) begin : g_bad_width
    $error("NUMBITS must be a multiple of 4");
  end

  logic [NG:0] cg;

  assign cg[0] = c_i;
  assign c_o   = cg[NG];

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a_i[k*W +: W] & b_i[k*W +: W];
    assign p    = a_i[k*W +: W] ^ b_i[k*W +: W];
    assign c[0] = cg[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | ((&p) & c[0]);

    assign s_o[k*W +: W] = p ^ c[3:0];
    assign cg[k+1]       = c[4];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder that reuses one narrow lookahead adder,
// one slice per cycle, LSB slice first.
module wide_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int TOTALBITS = 32,
  parameter int SLICEBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TOTALBITS-1:0] a_in,
  input  logic [TOTALBITS-1:0] b_in,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOTALBITS-1:0] s_out,
  output logic                 c_out,
  output logic                 ovf
);

  localparam int NUMSLICES = TOTALBITS / SLICEBITS;
  localparam int CW  = (NUMSLICES > 1) ? $clog2(NUMSLICES) : 1;
  localparam int MSB = TOTALBITS - 1;
  localparam logic [CW-1:0] LAST = CW'(NUMSLICES - 1);

  if ((TOTALBITS % SLICEBITS != 0) ||
      (SLICEBITS % CLA_BASE_WIDTH != 0)) begin : g_bad_cfg
    $error("TOTALBITS/SLICEBITS geometry is illegal");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TOTALBITS-1:0] a_q, a_d;
  logic [TOTALBITS-1:0] b_q, b_d;
  logic [TOTALBITS-1:0] s_q, s_d;
  logic                 carry_q, carry_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  int unsigned          lsb;
  logic [SLICEBITS-1:0] add_a, add_b, add_s;
  logic                 add_co;

  always_comb begin
    lsb   = slice_lsb(32'(cnt_q), SLICEBITS);
    add_a = a_q[lsb +: SLICEBITS];
    add_b = b_q[lsb +: SLICEBITS];
  end

  nBitCarryLookAheadAdder #(
    .NUMBITS(SLICEBITS)
  ) u_cla (
    .a_i(add_a),
    .b_i(add_b),
    .c_i(carry_q),
    .s_o(add_s),
    .c_o(add_co)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[lsb +: SLICEBITS] = add_s;
        carry_d = add_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // top slice's sum MSB is the result sign bit
          cout_d  = add_co;
          ovf_d   = (a_q[MSB] == b_q[MSB]) &&
                    (add_s[SLICEBITS-1] != a_q[MSB]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s_out = s_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed checks for the sliced wide adder:
// latency, carries, overflow, backpressure, reset abort.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s_out;
  logic        c_out;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .TOTALBITS(32),
    .SLICEBITS(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s_out    (s_out),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Accept one operation, then return cycles until out_valid.
  task automatic launch(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic c,
                        output int lat);
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    c_in     = c;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      lat = i;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      lat = -1;
    end
  endtask

  task automatic result(input string tag,
                        input logic [31:0] es,
                        input logic ec,
                        input logic eo);
    chk({tag, "_s"},   s_out,         es);
    chk({tag, "_c"},   32'(c_out),    32'(ec));
    chk({tag, "_ovf"}, 32'(ovf),      32'(eo));
    chk({tag, "_ir"},  32'(in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_drop_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ir"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held_s;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ir",  32'(in_ready),  32'd1);
    chk("rst_ov",  32'(out_valid), 32'd0);
    chk("rst_s",   s_out,          32'd0);
    chk("rst_c",   32'(c_out),     32'd0);
    chk("rst_ovf", 32'(ovf),       32'd0);

    // 2: slice-0 carry into slice 1, latency 4
    launch(32'h000000FF, 32'h00000001, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    result("t2", 32'h00000100, 1'b0, 1'b0);
    drain("t2");

    // 3: carry ripples through every pass
    launch(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
    chk("t3_latency", 32'(lat), 32'd4);
    result("t3", 32'h00000000, 1'b1, 1'b0);
    drain("t3");

    // 4: signed overflow, carry reg reloaded from c_in
    launch(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    result("t4a", 32'h80000000, 1'b0, 1'b1);
    drain("t4a");
    launch(32'h80000000, 32'h80000000, 1'b0, lat);
    result("t4b", 32'h00000000, 1'b1, 1'b1);
    drain("t4b");

    // 5: backpressure
    out_ready = 1'b0;
    launch(32'h00001234, 32'h00004321, 1'b0, lat);
    result("t5", 32'h00005555, 1'b0, 1'b0);
    held_s = s_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_in     = 32'hAAAAAAAA;
      b_in     = 32'h55555555;
      c_in     = 1'b1;
      in_valid = i[0];
      @(posedge clk);
      #1;
      chk("t5_hold_ov",  32'(out_valid), 32'd1);
      chk("t5_hold_s",   s_out,          held_s);
      chk("t5_hold_c",   32'(c_out),     32'd0);
      chk("t5_hold_ovf", 32'(ovf),       32'd0);
      chk("t5_hold_ir",  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("t5");
    launch(32'h89ABCDEF, 32'h12345678, 1'b1, lat);
    chk("t5b_latency", 32'(lat), 32'd4);
    result("t5b", 32'h9BE02468, 1'b0, 1'b0);
    drain("t5b");

    // 6: reset in the second RUN cycle aborts
    @(negedge clk);
    a_in     = 32'h12345678;
    b_in     = 32'h11111111;
    c_in     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_run_ov", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6_abort_ir", 32'(in_ready),  32'd1);
    chk("t6_abort_ov", 32'(out_valid), 32'd0);
    chk("t6_abort_s",  s_out,          32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_ov", 32'(out_valid), 32'd0);
    end
    launch(32'h00000001, 32'h00000001, 1'b0, lat);
    chk("t6_latency", 32'(lat), 32'd4);
    result("t6", 32'h00000002, 1'b0, 1'b0);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
